mda_motor_control_duty_ramp: RTL and testbench

Slew-rate limiter and command conditioner that sits directly upstream of the motor PWM generator; one instance per H-bridge.
- Accepts target duty/on commands from the CPU-side register interface.
- Drives the PWM generator's on / duty_cycle inputs, ramping duty gradually toward the target.
- On a direction reversal, forces a pass through brake (duty = period/2) and a dwell there before crossing.
- Duty encoding is centred at 50% (brake): above period/2 is forward, below is reverse.

---
 rtl/mda_motor_control_duty_ramp_pkg.sv | 13 +
 rtl/mda_motor_control_tick_gen.sv | 30 +++
 rtl/mda_motor_control_duty_ramp.sv | 191 +++++++++++++++++++
 tb/tb_mda_motor_control_duty_ramp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mda_motor_control_duty_ramp_pkg.sv
// Shared types for the motor duty-ramp slice: ramp state encoding and defaults.
package mda_motor_control_duty_ramp_pkg;

  localparam int unsigned PERIOD_LENGTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    RAMP_IDLE  = 2'd0,
    RAMP_RAMP  = 2'd1,
    RAMP_DWELL = 2'd2,
    RAMP_HOLD  = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/mda_motor_control_tick_gen.sv
// Free-running divide-by-DIV prescaler; tick is high while the count sits at DIV-1.
// clr restarts the count (used by the command watchdog; tied low for the ramp prescaler).
module mda_motor_control_tick_gen #(
  parameter int unsigned DIV = 1600
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'((DIV > 0) ? DIV - 1 : 0);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; synchronous clear restarts from zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/mda_motor_control_duty_ramp.sv
// Duty slew limiter ahead of the PWM generator, with forced brake dwell on reversal.
// Optional command watchdog: define MDA_MOTOR_CONTROL_WATCHDOG_EN.
module mda_motor_control_duty_ramp
  import mda_motor_control_duty_ramp_pkg::*;
#(
  parameter int unsigned PERIOD_LENGTH = PERIOD_LENGTH_DEFAULT,
  parameter int unsigned RAMP_DIV      = 1600,
  parameter int unsigned DWELL_TICKS   = 16,
  parameter int unsigned WDOG_CYCLES   = 16000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic                     cmd_on,
  input  logic [PERIOD_LENGTH-1:0] cmd_duty,
  input  logic [PERIOD_LENGTH-1:0] period,
  input  logic [PERIOD_LENGTH-1:0] step,
  output logic                     on,
  output logic [PERIOD_LENGTH-1:0] duty_cycle,
  output logic                     at_target,
  output logic                     busy
);

  localparam int unsigned PL         = PERIOD_LENGTH;
  localparam int unsigned DW         = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL_TICKS > 0) ? DWELL_TICKS - 1 : 0);

  if (RAMP_DIV < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("RAMP_DIV and WDOG_CYCLES must be at least 1");
  end

  ramp_state_t   state, state_n;
  logic          on_n, at_target_n, busy_n;
  logic [PL-1:0] duty_n, target, target_n;
  logic [DW-1:0] dwell_cnt, dwell_n;
  logic          left_fwd, left_fwd_n;
  logic          tick;

  logic [PL-1:0] half, step_eff, target_clamped, goal, duty_mv;
  logic [PL:0]   up_sum;
  logic          same_side, goal_up;

  mda_motor_control_tick_gen #(.DIV(RAMP_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .tick  (tick)
  );

`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
  logic wd_tick, wd_trip, wd_trip_n;

  mda_motor_control_tick_gen #(.DIV(WDOG_CYCLES)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (cmd_valid),
    .tick  (wd_tick)
  );

  // Trip flag: set on command silence, cleared by the next command.
  always_ff @(posedge clk) begin
    if (reset) wd_trip <= 1'b0;
    else       wd_trip <= wd_trip_n;
  end
`endif

  // One candidate ramp move: toward target if on the same side, else toward brake.
  always_comb begin
    half           = period >> 1;
    step_eff       = (step == '0) ? PL'(1) : step;
    target_clamped = (cmd_duty > period) ? period : cmd_duty;
    same_side      = ((target >= half) && (duty_cycle >= half)) ||
                     ((target <= half) && (duty_cycle <= half));
    goal           = same_side ? target : half;
    goal_up        = (goal > duty_cycle);
    up_sum         = {1'b0, duty_cycle} + {1'b0, step_eff};
    if (goal_up) begin
      duty_mv = (up_sum >= {1'b0, goal}) ? goal : up_sum[PL-1:0];
    end else begin
      duty_mv = ((duty_cycle - goal) <= step_eff) ? goal : (duty_cycle - step_eff);
    end
  end

  // Next-state logic; priority: command, period clamp, watchdog, ramp tick.
  always_comb begin
    state_n    = state;
    on_n       = on;
    duty_n     = duty_cycle;
    target_n   = target;
    dwell_n    = dwell_cnt;
    left_fwd_n = left_fwd;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
    wd_trip_n  = wd_trip;
`endif
    if (cmd_valid) begin
      target_n = target_clamped;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
      wd_trip_n = 1'b0;
`endif
      if (!cmd_on) begin
        on_n    = 1'b0;
        duty_n  = half;
        state_n = RAMP_IDLE;
        dwell_n = '0;
      end else begin
        unique case (state)
          RAMP_IDLE: begin
            on_n    = 1'b1;
            duty_n  = half;
            state_n = RAMP_RAMP;
            dwell_n = '0;
          end
          RAMP_RAMP: ;
          RAMP_DWELL: begin
            if (!(left_fwd ? (target_clamped < half) : (target_clamped > half))) begin
              state_n = RAMP_RAMP;
              dwell_n = '0;
            end
          end
          RAMP_HOLD: begin
            if (target_clamped != duty_cycle) state_n = RAMP_RAMP;
          end
        endcase
      end
    end else if (duty_cycle > period) begin
      duty_n = period;
`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
    end else if (wd_tick && on && !wd_trip) begin
      target_n  = half;
      wd_trip_n = 1'b1;
      if (state == RAMP_HOLD && duty_cycle != half) state_n = RAMP_RAMP;
    end else if (wd_trip && on && duty_cycle == half) begin
      on_n    = 1'b0;
      state_n = RAMP_IDLE;
      dwell_n = '0;
`endif
    end else if (tick) begin
      unique case (state)
        RAMP_RAMP: begin
          if (duty_cycle == target) begin
            state_n = RAMP_HOLD;
          end else begin
            duty_n = duty_mv;
            if (duty_mv == target) begin
              state_n = RAMP_HOLD;
            end else if (!same_side && duty_mv == half && DWELL_TICKS > 0) begin
              state_n    = RAMP_DWELL;
              dwell_n    = '0;
              left_fwd_n = (duty_cycle > half);
            end
          end
        end
        RAMP_DWELL: begin
          if (dwell_cnt == DWELL_LAST) begin
            state_n = RAMP_RAMP;
            dwell_n = '0;
          end else begin
            dwell_n = dwell_cnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
    at_target_n = on_n && (duty_n == target_n);
    busy_n      = (state_n == RAMP_RAMP) || (state_n == RAMP_DWELL);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RAMP_IDLE;
      on         <= 1'b0;
      duty_cycle <= period >> 1;
      target     <= period >> 1;
      dwell_cnt  <= '0;
      left_fwd   <= 1'b0;
      at_target  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      on         <= on_n;
      duty_cycle <= duty_n;
      target     <= target_n;
      dwell_cnt  <= dwell_n;
      left_fwd   <= left_fwd_n;
      at_target  <= at_target_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_mda_motor_control_duty_ramp.sv
// Directed bench for mda_motor_control_duty_ramp (period 1000, RAMP_DIV 4, DWELL_TICKS 2).
module tb_mda_motor_control_duty_ramp;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_on;
  logic [15:0] cmd_duty, period, step;
  logic        on, at_target, busy;
  logic [15:0] duty_cycle;

  int checks   = 0;
  int failures = 0;
  int n;

  mda_motor_control_duty_ramp #(
    .PERIOD_LENGTH (16),
    .RAMP_DIV      (4),
    .DWELL_TICKS   (2),
    .WDOG_CYCLES   (40)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_on     (cmd_on),
    .cmd_duty   (cmd_duty),
    .period     (period),
    .step       (step),
    .on         (on),
    .duty_cycle (duty_cycle),
    .at_target  (at_target),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic o, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_on    = o;
    cmd_duty  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for duty_cycle to change; returns cycles waited.
  task automatic wait_change(input int budget, output int cyc);
    logic [15:0] prev;
    prev = duty_cycle;
    cyc  = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (duty_cycle !== prev) break;
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_on = 1'b0; cmd_duty = '0;
    period = 16'd1000; step = 16'd100;
    repeat (2) @(negedge clk);
    chk("rst_on",   32'(on), 0);
    chk("rst_duty", 32'(duty_cycle), 500);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_at",   32'(at_target), 0);
    reset = 1'b0;

    // Forward ramp
    send(1'b1, 16'd800);
    chk("fwd_on", 32'(on), 1);
    chk("fwd_duty0", 32'(duty_cycle), 500);
    chk("fwd_busy", 32'(busy), 1);
    wait_change(8, n);  chk("fwd_600", 32'(duty_cycle), 600);
    wait_change(8, n);  chk("fwd_700", 32'(duty_cycle), 700); chk("fwd_gap", 32'(n), 4);
    wait_change(8, n);  chk("fwd_800", 32'(duty_cycle), 800); chk("fwd_gap2", 32'(n), 4);
    chk("fwd_at", 32'(at_target), 1);
    chk("fwd_idle", 32'(busy), 0);
    repeat (8) @(negedge clk);
    chk("hold_800", 32'(duty_cycle), 800);

    // Reversal with brake dwell
    send(1'b1, 16'd200);
    chk("rev_busy", 32'(busy), 1);
    chk("rev_at", 32'(at_target), 0);
    wait_change(8, n);  chk("rev_700", 32'(duty_cycle), 700);
    wait_change(8, n);  chk("rev_600", 32'(duty_cycle), 600);
    wait_change(8, n);  chk("rev_500", 32'(duty_cycle), 500);
    chk("dwell_busy", 32'(busy), 1);
    wait_change(20, n); chk("rev_400", 32'(duty_cycle), 400); chk("dwell_len", 32'(n), 12);
    wait_change(8, n);  chk("rev_300", 32'(duty_cycle), 300);
    wait_change(8, n);  chk("rev_200", 32'(duty_cycle), 200);
    chk("rev_at_done", 32'(at_target), 1);
    chk("rev_idle", 32'(busy), 0);

    // Overshoot clamp and target clamp
    send(1'b0, 16'd0);
    chk("off_on", 32'(on), 0);
    chk("off_duty", 32'(duty_cycle), 500);
    step = 16'd300;
    send(1'b1, 16'd750);
    wait_change(8, n);  chk("clamp_750", 32'(duty_cycle), 750);
    chk("clamp_750_at", 32'(at_target), 1);
    send(1'b1, 16'd1200);
    wait_change(8, n);  chk("clamp_1000", 32'(duty_cycle), 1000);
    chk("clamp_1000_at", 32'(at_target), 1);

    // Abort mid-ramp
    send(1'b0, 16'd0);
    step = 16'd150;
    send(1'b1, 16'd950);
    wait_change(8, n);  chk("abort_650", 32'(duty_cycle), 650);
    send(1'b0, 16'd0);
    chk("abort_on", 32'(on), 0);
    chk("abort_duty", 32'(duty_cycle), 500);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_at", 32'(at_target), 0);

    // Command coinciding with a tick: no step that cycle
    step = 16'd100;
    send(1'b1, 16'd800);
    wait_change(8, n);  chk("coin_600", 32'(duty_cycle), 600);
    repeat (3) @(negedge clk);
    send(1'b1, 16'd900);
    chk("coin_nostep", 32'(duty_cycle), 600);
    wait_change(8, n);  chk("coin_700", 32'(duty_cycle), 700); chk("coin_gap", 32'(n), 4);
    wait_change(8, n);  chk("coin_800", 32'(duty_cycle), 800);
    wait_change(8, n);  chk("coin_900", 32'(duty_cycle), 900);
    chk("coin_at", 32'(at_target), 1);

    // Step of zero behaves as one
    step = 16'd0;
    send(1'b1, 16'd903);
    wait_change(8, n);  chk("step0_901", 32'(duty_cycle), 901);
    wait_change(8, n);  chk("step0_902", 32'(duty_cycle), 902);

    // Reset mid-ramp
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_on", 32'(on), 0);
    chk("mid_rst_duty", 32'(duty_cycle), 500);
    chk("mid_rst_busy", 32'(busy), 0);

    // Period shrink clamps duty
    step = 16'd100;
    send(1'b1, 16'd700);
    wait_change(8, n);  chk("per_600", 32'(duty_cycle), 600);
    wait_change(8, n);  chk("per_700", 32'(duty_cycle), 700);
    period = 16'd650;
    @(negedge clk);
    chk("per_clamp", 32'(duty_cycle), 650);
    period = 16'd1000;

`ifdef MDA_MOTOR_CONTROL_WATCHDOG_EN
    // Command silence ramps back to brake and drops on
    send(1'b0, 16'd0);
    send(1'b1, 16'd800);
    wait_change(8, n);  chk("wd_600", 32'(duty_cycle), 600);
    wait_change(8, n);  chk("wd_700", 32'(duty_cycle), 700);
    wait_change(8, n);  chk("wd_800", 32'(duty_cycle), 800);
    wait_change(60, n); chk("wd_dn_700", 32'(duty_cycle), 700);
    wait_change(8, n);  chk("wd_dn_600", 32'(duty_cycle), 600);
    wait_change(8, n);  chk("wd_dn_500", 32'(duty_cycle), 500);
    @(negedge clk);
    chk("wd_off", 32'(on), 0);
    chk("wd_busy", 32'(busy), 0);
    send(1'b1, 16'd600);
    chk("wd_resume_on", 32'(on), 1);
    wait_change(8, n);  chk("wd_resume_600", 32'(duty_cycle), 600);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
